// File: rtl/comparador_secuencial.sv
// rtl/comparador_secuencial.sv - binary-search segment locator over a loadable sorted threshold table
module comparador_secuencial #(
   parameter int Width     = 24,
   parameter int IdxBits   = 5,
   parameter bit Inclusive = 1'b1
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      InValid,
   output logic                      InReady,
   input  logic signed [Width-1:0]   A,
   input  logic                      WrEn,
   input  logic        [IdxBits-1:0] WrAddr,
   input  logic signed [Width-1:0]   WrData,
   output logic                      WrDrop,
   output logic                      OutValid,
   input  logic                      OutReady,
   output logic        [IdxBits-1:0] OutComp,
   output logic                      OutSat
);

   localparam int NSeg  = 1 << IdxBits;
   localparam int StepW = (IdxBits > 1) ? $clog2(IdxBits) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SEARCH = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic        [1:0]         r_state;
   logic signed [Width-1:0]   r_a;
   logic        [IdxBits-1:0] r_lo;
   logic        [StepW-1:0]   r_step;
   logic        [IdxBits-1:0] r_comp;
   logic                      r_sat;
   logic                      r_out_valid;
   logic                      r_wr_drop;
   logic signed [Width-1:0]   r_table [0:NSeg-1];

   logic        [IdxBits-1:0] w_pow;
   logic        [IdxBits-1:0] w_probe;
   logic signed [Width-1:0]   w_thr;
   logic                      w_go_right;
   logic        [IdxBits-1:0] w_lo_next;

   // The probe index never exceeds 2^IdxBits-2, so the top slot is never read.
   assign w_pow      = IdxBits'(1) << r_step;
   assign w_probe    = r_lo + w_pow - IdxBits'(1);
   assign w_thr      = r_table[w_probe];
   assign w_go_right = Inclusive ? (r_a > w_thr) : (r_a >= w_thr);
   assign w_lo_next  = w_go_right ? (r_lo + w_pow) : r_lo;

   assign InReady  = (r_state == S_IDLE);
   assign OutValid = r_out_valid;
   assign OutComp  = r_comp;
   assign OutSat   = r_sat;
   assign WrDrop   = r_wr_drop;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_lo        <= '0;
         r_step      <= '0;
         r_comp      <= '0;
         r_sat       <= 1'b0;
         r_out_valid <= 1'b0;
         r_wr_drop   <= 1'b0;
         for (int i = 0; i < NSeg; i++) begin
            r_table[i] <= '0;
         end
      end else begin
         r_wr_drop <= 1'b0;
         if (WrEn) begin
            if ((r_state == S_IDLE) && (WrAddr != IdxBits'(NSeg - 1))) begin
               r_table[WrAddr] <= WrData;
            end else begin
               r_wr_drop <= 1'b1;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (InValid) begin
                  r_a     <= A;
                  r_lo    <= '0;
                  r_step  <= StepW'(IdxBits - 1);
                  r_state <= S_SEARCH;
               end
            end
            S_SEARCH: begin
               r_lo <= w_lo_next;
               if (r_step == '0) begin
                  r_comp      <= w_lo_next;
                  r_sat       <= (w_lo_next == '0) || (w_lo_next == '1);
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_step <= r_step - StepW'(1);
               end
            end
            S_DONE: begin
               if (OutReady) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_comparador_secuencial.sv
// tb/tb_comparador_secuencial.sv - directed and table-driven checks for comparador_secuencial
module tb_comparador_secuencial;

   logic               CLK = 1'b0;
   logic               RST;
   logic               InValid;
   logic signed [23:0] A;
   logic               WrEn;
   logic        [2:0]  WrAddr;
   logic signed [23:0] WrData;
   logic               OutReady;

   logic       rdy_i, wdrop_i, ov_i, sat_i;
   logic [2:0] comp_i;
   logic       rdy_e, wdrop_e, ov_e, sat_e;
   logic [2:0] comp_e;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   comparador_secuencial #(.Width(24), .IdxBits(3), .Inclusive(1'b1)) u_inc (
      .CLK(CLK), .RST(RST), .InValid(InValid), .InReady(rdy_i), .A(A),
      .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrDrop(wdrop_i),
      .OutValid(ov_i), .OutReady(OutReady), .OutComp(comp_i), .OutSat(sat_i)
   );

   comparador_secuencial #(.Width(24), .IdxBits(3), .Inclusive(1'b0)) u_exc (
      .CLK(CLK), .RST(RST), .InValid(InValid), .InReady(rdy_e), .A(A),
      .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrDrop(wdrop_e),
      .OutValid(ov_e), .OutReady(OutReady), .OutComp(comp_e), .OutSat(sat_e)
   );

   typedef struct {
      int a;
      int ci;
      int ce;
   } vec_t;

   vec_t vecs[9];
   int   thr[7];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic write_tbl(input int addr, input int data);
      WrEn   = 1'b1;
      WrAddr = 3'(addr);
      WrData = 24'(data);
      tick();
      WrEn   = 1'b0;
   endtask

   task automatic wait_valid(output int k);
      k = 0;
      while (!ov_i && k < 20) begin
         tick();
         k++;
      end
      check("out_valid_timeout", int'(ov_i), 1);
   endtask

   function automatic int sat_of(input int c);
      return (c == 0 || c == 7) ? 1 : 0;
   endfunction

   // Accept one sample, check latency, both results and saturation flags, then drain.
   task automatic run_sample(input string name, input int a, input int ci, input int ce);
      int k;
      InValid = 1'b1;
      A       = 24'(a);
      check({name, "_in_ready"}, int'(rdy_i), 1);
      tick();
      InValid = 1'b0;
      wait_valid(k);
      check({name, "_latency"}, k, 3);
      check({name, "_comp_inc"}, int'(comp_i), ci);
      check({name, "_comp_exc"}, int'(comp_e), ce);
      check({name, "_sat_inc"}, int'(sat_i), sat_of(ci));
      check({name, "_sat_exc"}, int'(sat_e), sat_of(ce));
      tick();
   endtask

   function automatic int model(input int a, input bit inc);
      for (int i = 0; i < 7; i++) begin
         if (inc ? (a <= thr[i]) : (a < thr[i])) return i;
      end
      return 7;
   endfunction

   initial begin
      int k;
      int last_acc;
      int v;

      vecs[0] = '{-300, 0, 1};
      vecs[1] = '{-299, 1, 1};
      vecs[2] = '{0, 3, 4};
      vecs[3] = '{1, 4, 4};
      vecs[4] = '{300, 6, 7};
      vecs[5] = '{301, 7, 7};
      vecs[6] = '{-8388608, 0, 0};
      vecs[7] = '{8388607, 7, 7};
      vecs[8] = '{150, 5, 5};

      RST = 1'b0; InValid = 1'b0; A = '0; WrEn = 1'b0; WrAddr = '0; WrData = '0; OutReady = 1'b1;
      tick();
      tick();
      check("rst_in_ready", int'(rdy_i), 1);
      check("rst_out_valid", int'(ov_i), 0);
      check("rst_comp", int'(comp_i), 0);
      check("rst_sat", int'(sat_i), 0);
      check("rst_wr_drop", int'(wdrop_i), 0);
      RST = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) write_tbl(i, -300 + 100 * i);
      tick();

      for (int i = 0; i < 9; i++) begin
         run_sample($sformatf("vec%0d", i), vecs[i].a, vecs[i].ci, vecs[i].ce);
      end

      // Output backpressure with a stray InValid pulse while DONE
      OutReady = 1'b0;
      InValid  = 1'b1;
      A        = 24'sd150;
      tick();
      InValid = 1'b0;
      wait_valid(k);
      for (int i = 0; i < 10; i++) begin
         InValid = (i == 4);
         A       = (i == 4) ? -24'sd1000 : 24'sd150;
         check("bp_out_valid", int'(ov_i), 1);
         check("bp_comp", int'(comp_i), 5);
         check("bp_in_ready", int'(rdy_i), 0);
         tick();
      end
      InValid  = 1'b0;
      check("bp_comp_after_pulse", int'(comp_i), 5);
      OutReady = 1'b1;
      tick();
      check("bp_release_in_ready", int'(rdy_i), 1);
      check("bp_release_out_valid", int'(ov_i), 0);

      // Write attempted during SEARCH must be dropped
      InValid = 1'b1;
      A       = 24'sd0;
      tick();
      InValid = 1'b0;
      WrEn = 1'b1; WrAddr = 3'd3; WrData = 24'sd999;
      tick();
      WrEn = 1'b0;
      check("search_wr_drop_pulse", int'(wdrop_i), 1);
      tick();
      check("search_wr_drop_clear", int'(wdrop_i), 0);
      wait_valid(k);
      check("search_wr_comp", int'(comp_i), 3);
      tick();
      run_sample("after_drop", 0, 3, 4);

      // Write and accept in the same IDLE cycle
      WrEn = 1'b1; WrAddr = 3'd3; WrData = 24'sd50;
      InValid = 1'b1; A = 24'sd20;
      tick();
      WrEn = 1'b0; InValid = 1'b0;
      check("same_cycle_no_drop", int'(wdrop_i), 0);
      wait_valid(k);
      check("same_cycle_comp_inc", int'(comp_i), 3);
      check("same_cycle_comp_exc", int'(comp_e), 3);
      tick();

      write_tbl(7, 12345);
      check("addr7_wr_drop", int'(wdrop_i), 1);
      tick();
      check("addr7_wr_drop_clear", int'(wdrop_i), 0);
      run_sample("addr7_table_ok", 301, 7, 7);

      // Reset two cycles into SEARCH
      InValid = 1'b1;
      A       = 24'sd5;
      tick();
      InValid = 1'b0;
      tick();
      RST = 1'b0;
      tick();
      RST = 1'b1;
      check("midrst_in_ready", int'(rdy_i), 1);
      check("midrst_out_valid", int'(ov_i), 0);
      tick();
      check("midrst_quiet", int'(ov_i), 0);
      run_sample("zero_tbl_a0", 0, 0, 7);
      run_sample("zero_tbl_a1", 1, 7, 7);

      // Random sorted table and back-to-back stream
      for (int i = 0; i < 7; i++) thr[i] = int'($urandom_range(0, 4000)) - 2000;
      for (int i = 1; i < 7; i++) begin
         for (int j = i; j > 0 && thr[j - 1] > thr[j]; j--) begin
            v = thr[j]; thr[j] = thr[j - 1]; thr[j - 1] = v;
         end
      end
      for (int i = 0; i < 7; i++) write_tbl(i, thr[i]);
      tick();
      OutReady = 1'b1;
      InValid  = 1'b1;
      last_acc = 0;
      for (int n = 0; n < 20; n++) begin
         case ($urandom_range(0, 2))
            0:       v = thr[$urandom_range(0, 6)];
            1:       v = thr[$urandom_range(0, 6)] + int'($urandom_range(0, 2)) - 1;
            default: v = int'($urandom_range(0, 5000)) - 2500;
         endcase
         A = 24'(v);
         check("stream_in_ready", int'(rdy_i), 1);
         tick();
         if (n > 0) check("stream_accept_spacing", cyc - last_acc, 5);
         last_acc = cyc;
         wait_valid(k);
         check($sformatf("stream%0d_inc", n), int'(comp_i), model(v, 1'b1));
         check($sformatf("stream%0d_exc", n), int'(comp_e), model(v, 1'b0));
         tick();
      end
      InValid = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
